// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/data/last sources.
// A grant lasts one burst. Priority rotates past the served source after each burst.
module fifo_wr_arb #(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int BURST_MAX = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arb_en,
    input  logic [N_REQ-1:0]    src_valid,
    input  logic [N_REQ*DW-1:0] src_data,
    input  logic [N_REQ-1:0]    src_last,
    output logic [N_REQ-1:0]    src_ready,
    output logic [N_REQ-1:0]    gnt,
    input  logic                fifo_full,
    output logic                fifo_wr_en,
    output logic [DW-1:0]       fifo_wr_data,
    output logic                busy
);

    // state   | meaning
    // S_IDLE  | no grant; picks next valid source from r_ptr when arb_en
    // S_BURST | source r_cur owns the FIFO port until last, cap or gap
    typedef enum logic {S_IDLE, S_BURST} state_t;

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t          r_state;
    logic [IW-1:0]   r_cur;
    logic [IW-1:0]   r_ptr;
    logic [7:0]      r_beat;
    logic [N_REQ-1:0] r_gnt;

    logic [DW-1:0]   w_data_arr [N_REQ];
    logic [IW-1:0]   w_idx;
    logic [IW-1:0]   w_pick;
    logic            w_found;
    logic [N_REQ-1:0] w_pick_oh;
    logic [IW-1:0]   w_ptr_next;
    logic            w_cur_valid;
    logic            w_cur_last;
    logic            w_accept;
    logic            w_end;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_data_arr[g] = src_data[g*DW +: DW];
    end

    // Walk from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = IW'((int'(r_ptr) + k) % N_REQ);
            if (src_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_pick_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
    assign w_ptr_next  = (r_cur == IW'(N_REQ - 1)) ? '0 : r_cur + 1'b1;
    assign w_cur_valid = src_valid[r_cur];
    assign w_cur_last  = src_last[r_cur];
    assign w_accept    = (r_state == S_BURST) && w_cur_valid && !fifo_full;

    // A gap wins over a full stall: full only holds the grant while data is waiting.
    assign w_end = (r_state == S_BURST) &&
                   (!w_cur_valid ||
                    (w_accept && (w_cur_last || (r_beat == 8'(BURST_MAX - 1)))));

    assign fifo_wr_en   = w_accept;
    assign fifo_wr_data = w_data_arr[r_cur];
    assign src_ready    = w_accept ? r_gnt : '0;
    assign gnt          = r_gnt;
    assign busy         = (r_state == S_BURST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_ptr   <= '0;
            r_beat  <= '0;
            r_gnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arb_en && w_found) begin
                        r_state <= S_BURST;
                        r_cur   <= w_pick;
                        r_gnt   <= w_pick_oh;
                        r_beat  <= '0;
                    end
                end
                S_BURST: begin
                    if (w_end) begin
                        r_state <= S_IDLE;
                        r_gnt   <= '0;
                        r_ptr   <= w_ptr_next;
                        r_beat  <= '0;
                    end else if (w_accept) begin
                        r_beat  <= r_beat + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: a per-cycle vector table, then source-model sequences
// for round robin, burst cap, full stall, gap, arb_en and reset mid-burst.
module tb_fifo_wr_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arb_en;
    logic [3:0]  src_valid;
    logic [31:0] src_data;
    logic [3:0]  src_last;
    logic [3:0]  src_ready;
    logic [3:0]  gnt;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        busy;

    fifo_wr_arb #(.N_REQ(4), .DW(8), .BURST_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
        .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
        .src_ready(src_ready), .gnt(gnt), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        full;
        logic        en;
        logic [3:0]  e_gnt;
        logic        e_wr;
        logic [7:0]  e_wd;
        logic [3:0]  e_rdy;
        logic        e_busy;
    } vec_t;

    vec_t vecs [17];

    int n_cmp = 0;
    int n_err = 0;

    int n_words [4];
    int sent    [4];
    int plen    [4];
    int cyc;
    int full_lo, full_hi, en_lo, en_hi;
    logic [3:0] glog [$];
    int         blen [$];
    logic       wpat [64];
    logic [3:0] gpat [64];
    int         wcount;
    logic [3:0] prev_gnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] word(input int i, input int n);
        return 8'(i * 40 + n + 1);
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            src_valid[i]        = (sent[i] < n_words[i]);
            src_data[i*8 +: 8]  = word(i, sent[i]);
            src_last[i]         = (sent[i] < n_words[i]) && (plen[i] != 0) &&
                                  (((sent[i] + 1) % plen[i]) == 0);
        end
        fifo_full = (cyc >= full_lo) && (cyc <= full_hi);
        arb_en    = !((cyc >= en_lo) && (cyc <= en_hi));
    endtask

    task automatic run(input int n);
        int acc;
        repeat (n) begin
            drive();
            @(negedge clk);
            acc = -1;
            if (gnt != 4'd0 && prev_gnt == 4'd0) begin
                glog.push_back(gnt);
                blen.push_back(0);
            end
            prev_gnt = gnt;
            if (cyc < 64) begin
                wpat[cyc] = fifo_wr_en;
                gpat[cyc] = gnt;
            end
            chk("busy_vs_gnt", 32'(busy), 32'(gnt != 4'd0));
            if (fifo_wr_en) begin
                chk("ready_eq_gnt", 32'(src_ready), 32'(gnt));
                chk("write_while_full", 32'(fifo_full), 32'd0);
                for (int i = 0; i < 4; i++)
                    if (src_ready[i]) acc = i;
                if (acc >= 0) begin
                    chk("wr_data", 32'(fifo_wr_data), 32'(word(acc, sent[acc])));
                    wcount++;
                    if (blen.size() > 0) blen[blen.size()-1] += 1;
                end
            end else begin
                chk("ready_no_write", 32'(src_ready), 32'd0);
            end
            @(posedge clk);
            #1;
            if (acc >= 0) sent[acc]++;
            cyc++;
        end
    endtask

    task automatic reset_all();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_words[i] = 0; sent[i] = 0; plen[i] = 0;
        end
        for (int c = 0; c < 64; c++) begin
            wpat[c] = 1'b0; gpat[c] = 4'd0;
        end
        glog.delete();
        blen.delete();
        wcount = 0; prev_gnt = 4'd0; cyc = 0;
        full_lo = 999; full_hi = 0; en_lo = 999; en_hi = 0;
        src_valid = 4'd0; src_last = 4'd0; src_data = 32'd0;
        fifo_full = 1'b0; arb_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // {valid, last, data, full, en, gnt, wr, wdata, ready, busy}
        vecs[0]  = '{4'b0100, 4'b0000, 32'h00110000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        vecs[1]  = '{4'b0100, 4'b0000, 32'h00110000, 1'b0, 1'b1, 4'b0100, 1'b1, 8'h11, 4'b0100, 1'b1};
        vecs[2]  = '{4'b0100, 4'b0000, 32'h00220000, 1'b0, 1'b1, 4'b0100, 1'b1, 8'h22, 4'b0100, 1'b1};
        vecs[3]  = '{4'b0100, 4'b0100, 32'h00330000, 1'b0, 1'b1, 4'b0100, 1'b1, 8'h33, 4'b0100, 1'b1};
        vecs[4]  = '{4'b0000, 4'b0000, 32'h00000000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        vecs[5]  = '{4'b1001, 4'b1001, 32'h3A00000A, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        vecs[6]  = '{4'b1001, 4'b1001, 32'h3A00000A, 1'b0, 1'b1, 4'b1000, 1'b1, 8'h3A, 4'b1000, 1'b1};
        vecs[7]  = '{4'b1001, 4'b1001, 32'h3B00000A, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        vecs[8]  = '{4'b1001, 4'b1001, 32'h3B00000A, 1'b0, 1'b1, 4'b0001, 1'b1, 8'h0A, 4'b0001, 1'b1};
        vecs[9]  = '{4'b1001, 4'b1001, 32'h3B00000B, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        vecs[10] = '{4'b1001, 4'b1001, 32'h3B00000B, 1'b1, 1'b1, 4'b1000, 1'b0, 8'h00, 4'b0000, 1'b1};
        vecs[11] = '{4'b1001, 4'b1001, 32'h3B00000B, 1'b0, 1'b1, 4'b1000, 1'b1, 8'h3B, 4'b1000, 1'b1};
        vecs[12] = '{4'b0001, 4'b0000, 32'h0000000C, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        vecs[13] = '{4'b0001, 4'b0000, 32'h0000000C, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        vecs[14] = '{4'b0001, 4'b0000, 32'h0000000C, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        vecs[15] = '{4'b0000, 4'b0000, 32'h00000000, 1'b1, 1'b1, 4'b0001, 1'b0, 8'h00, 4'b0000, 1'b1};
        vecs[16] = '{4'b0000, 4'b0000, 32'h00000000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};

        // Reset values with every source requesting.
        rst_n = 1'b0; arb_en = 1'b1; fifo_full = 1'b0;
        src_valid = 4'b1111; src_last = 4'd0; src_data = 32'h44332211;
        #12;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_ready", 32'(src_ready), 32'd0);

        reset_all();
        for (int v = 0; v < 17; v++) begin
            src_valid = vecs[v].valid;
            src_last  = vecs[v].last;
            src_data  = vecs[v].data;
            fifo_full = vecs[v].full;
            arb_en    = vecs[v].en;
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", v), 32'(gnt), 32'(vecs[v].e_gnt));
            chk($sformatf("vec%0d_wr_en", v), 32'(fifo_wr_en), 32'(vecs[v].e_wr));
            chk($sformatf("vec%0d_ready", v), 32'(src_ready), 32'(vecs[v].e_rdy));
            chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].e_busy));
            if (vecs[v].e_wr)
                chk($sformatf("vec%0d_wdata", v), 32'(fifo_wr_data), 32'(vecs[v].e_wd));
            @(posedge clk);
            #1;
        end

        // Round robin, 2-word packets from all four sources.
        reset_all();
        for (int i = 0; i < 4; i++) begin n_words[i] = 4; plen[i] = 2; end
        run(12);
        chk("rr_writes_12cyc", 32'(wcount), 32'd8);
        for (int c = 0; c < 12; c++)
            chk($sformatf("rr_pat_c%0d", c), 32'(wpat[c]), 32'((c % 3) != 0));
        run(3);
        chk("rr_grants", 32'(glog.size()), 32'd5);
        if (glog.size() == 5) begin
            chk("rr_g0", 32'(glog[0]), 32'b0001);
            chk("rr_g1", 32'(glog[1]), 32'b0010);
            chk("rr_g2", 32'(glog[2]), 32'b0100);
            chk("rr_g3", 32'(glog[3]), 32'b1000);
            chk("rr_g4", 32'(glog[4]), 32'b0001);
        end

        // Burst cap: 20 words, no last, from source 1.
        reset_all();
        n_words[1] = 20;
        run(26);
        chk("cap_words", 32'(wcount), 32'd20);
        chk("cap_grants", 32'(blen.size()), 32'd3);
        if (blen.size() == 3) begin
            chk("cap_b0", 32'(blen[0]), 32'd8);
            chk("cap_b1", 32'(blen[1]), 32'd8);
            chk("cap_b2", 32'(blen[2]), 32'd4);
        end
        for (int c = 0; c < 26; c++)
            chk($sformatf("cap_pat_c%0d", c), 32'(wpat[c]),
                32'((c >= 1 && c <= 8) || (c >= 10 && c <= 17) || (c >= 19 && c <= 22)));

        // Full stall during burst cycles 3..6 of a 6-word packet.
        reset_all();
        n_words[0] = 6; plen[0] = 6;
        full_lo = 3; full_hi = 6;
        run(13);
        chk("stall_words", 32'(wcount), 32'd6);
        chk("stall_grants", 32'(glog.size()), 32'd1);
        for (int c = 3; c <= 6; c++) begin
            chk($sformatf("stall_wr_c%0d", c), 32'(wpat[c]), 32'd0);
            chk($sformatf("stall_gnt_c%0d", c), 32'(gpat[c]), 32'b0001);
        end
        chk("stall_resume", 32'(wpat[7]), 32'd1);
        chk("stall_done", 32'(gpat[11]), 32'd0);

        // Gap: source 0 runs dry after 2 words, source 1 is served next.
        reset_all();
        n_words[0] = 2;
        n_words[1] = 2; plen[1] = 2;
        run(9);
        chk("gap_words", 32'(wcount), 32'd4);
        chk("gap_grants", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            chk("gap_g0", 32'(glog[0]), 32'b0001);
            chk("gap_g1", 32'(glog[1]), 32'b0010);
        end
        chk("gap_src0_sent", 32'(sent[0]), 32'd2);

        // arb_en drops mid-burst: burst finishes, no new grant until re-enabled.
        reset_all();
        n_words[2] = 4; plen[2] = 4;
        n_words[3] = 2; plen[3] = 2;
        en_lo = 2; en_hi = 11;
        run(12);
        chk("en_src2_done", 32'(sent[2]), 32'd4);
        chk("en_held_grants", 32'(glog.size()), 32'd1);
        chk("en_src3_blocked", 32'(sent[3]), 32'd0);
        run(5);
        chk("en_src3_served", 32'(sent[3]), 32'd2);
        if (glog.size() == 2) chk("en_g1", 32'(glog[1]), 32'b1000);
        else chk("en_grants_after", 32'(glog.size()), 32'd2);

        // Reset during beat 3 of a source-1 burst, with ptr moved to 3 beforehand.
        reset_all();
        n_words[2] = 1; plen[2] = 1;
        run(3);
        n_words[1] = 8;
        run(4);
        drive();
        #2;
        chk("rstmid_pre_wr", 32'(fifo_wr_en), 32'd1);
        chk("rstmid_pre_gnt", 32'(gnt), 32'b0010);
        rst_n = 1'b0;
        #1;
        chk("rstmid_gnt", 32'(gnt), 32'd0);
        chk("rstmid_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_ready", 32'(src_ready), 32'd0);
        reset_all();
        n_words[3] = 1; plen[3] = 1;
        n_words[0] = 1; plen[0] = 1;
        run(6);
        chk("rstmid_grants", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            chk("rstmid_first", 32'(glog[0]), 32'b0001);
            chk("rstmid_second", 32'(glog[1]), 32'b1000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
